// File: rtl/segway_uart_pkg.sv
// Shared types and defaults for the Segway BLE command UART receiver.
// Holds the receive FSM state enum and the default baud/command values.
package segway_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } rx_state_t;

    // 50 MHz clock / 9600 baud
    localparam int         BAUD_DIV_DEFAULT = 5208;

    // 'G' starts the Segway, 'S' stops it
    localparam logic [7:0] CMD_GO_DEFAULT   = 8'h47;
    localparam logic [7:0] CMD_STOP_DEFAULT = 8'h53;

endpackage

// File: rtl/rx_synch_edge.sv
// Two-flop synchronizer for the asynchronous RX line plus falling-edge detect.
// Ports: clk, rst (async, active-high), rx_i (raw line), rx_sync_o
// (synchronized level), fall_o (one-cycle pulse on a synchronized 1->0 transition).
module rx_synch_edge (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // All flops preset to 1 so an idle line never looks like a start edge
    // coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= sync_q[1];
        end
    end

    assign rx_sync_o = sync_q[1];
    assign fall_o    = ~sync_q[1] & prev_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 LSB-first UART receiver that frames BLE command bytes and decodes the
// Segway go/stop commands.
// Ports: clk, rst (async, active-high), RX (serial in, idle high), clr_rdy
// (consumer ack); rx_data (last good byte), rdy (byte pending until clr_rdy),
// frm_err / ovr / go_cmd / stop_cmd (one-cycle pulses).
module uart_cmd_rx
    import segway_uart_pkg::*;
#(
    parameter int         BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter logic [7:0] CMD_GO   = CMD_GO_DEFAULT,
    parameter logic [7:0] CMD_STOP = CMD_STOP_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr,
    output logic       go_cmd,
    output logic       stop_cmd
);

    localparam int              CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   FULL = CW'(BAUD_DIV - 1);
    // Half a bit from the start edge lands every later sample mid-bit.
    localparam logic [CW-1:0]   HALF = CW'(BAUD_DIV / 2 - 1);

    logic rx_s;
    logic fall;

    rx_synch_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (RX),
        .rx_sync_o (rx_s),
        .fall_o    (fall)
    );

    rx_state_t     state_q, state_d;
    logic [CW-1:0] baud_q,  baud_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q,  data_d;
    logic          rdy_q,   rdy_d;
    logic          frm_q,   frm_d;
    logic          ovr_q,   ovr_d;
    logic          go_q,    go_d;
    logic          stop_q,  stop_d;
    logic          tick;

    assign tick = (baud_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            frm_q   <= 1'b0;
            ovr_q   <= 1'b0;
            go_q    <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            frm_q   <= frm_d;
            ovr_q   <= ovr_d;
            go_q    <= go_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        frm_d   = 1'b0;
        ovr_d   = 1'b0;
        go_d    = 1'b0;
        stop_d  = 1'b0;

        // Ack is honoured in every state; a new byte below overrides it.
        if (clr_rdy) begin
            rdy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    baud_d  = HALF;
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        bit_d   = 3'd0;
                        baud_d  = FULL;
                        state_d = DATA;
                    end else begin
                        // Line back high mid start bit: a glitch, drop it.
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            DATA: begin
                if (tick) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rx_s, shift_q[7:1]};
                    baud_d  = FULL;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        rdy_d   = 1'b1;
                        ovr_d   = rdy_q;
                        go_d    = (shift_q == CMD_GO);
                        stop_d  = (shift_q == CMD_STOP);
                        state_d = IDLE;
                    end else begin
                        frm_d   = 1'b1;
                        state_d = WAIT_HI;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            // A break holds the line low; wait for idle so its end is not
            // taken for a new start bit.
            WAIT_HI: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data  = data_q;
    assign rdy      = rdy_q;
    assign frm_err  = frm_q;
    assign ovr      = ovr_q;
    assign go_cmd   = go_q;
    assign stop_cmd = stop_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: directed command/error cases plus a
// randomized byte stream checked against a frame-level reference model.
module tb_uart_cmd_rx;

    localparam int         B      = 32;
    localparam logic [7:0] GO     = 8'h47;
    localparam logic [7:0] STP    = 8'h53;
    localparam int         LAT    = (B * 19) / 2 + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr;
    logic       go_cmd;
    logic       stop_cmd;

    uart_cmd_rx #(
        .BAUD_DIV (B),
        .CMD_GO   (GO),
        .CMD_STOP (STP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .clr_rdy  (clr_rdy),
        .rx_data  (rx_data),
        .rdy      (rdy),
        .frm_err  (frm_err),
        .ovr      (ovr),
        .go_cmd   (go_cmd),
        .stop_cmd (stop_cmd)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errs = 0;
    int   checks = 0;
    int   n_go = 0, n_stop = 0, n_frm = 0, n_ovr = 0;
    int   rise_cyc = -1;
    logic rdy_prev = 1'b0;

    // Reference model: what the consumer should see at frame level.
    logic       mdl_rdy = 1'b0;
    logic [7:0] mdl_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            rdy_prev = 1'b0;
        end else begin
            n_go   = n_go + int'(go_cmd);
            n_stop = n_stop + int'(stop_cmd);
            n_frm  = n_frm + int'(frm_err);
            n_ovr  = n_ovr + int'(ovr);
            if (rdy && !rdy_prev) rise_cyc = cyc;
            rdy_prev = rdy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_go = 0; n_stop = 0; n_frm = 0; n_ovr = 0; rise_cyc = -1;
    endtask

    task automatic send(input logic [7:0] v, input bit stop_ok);
        int start;
        bit exp_rise;
        @(negedge clk);
        clear_counts();
        exp_rise = stop_ok && !mdl_rdy;
        RX = 1'b0;
        start = cyc;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = v[i];
            repeat (B) @(negedge clk);
        end
        RX = stop_ok;
        repeat (B) @(negedge clk);
        if (!stop_ok) begin
            RX = 1'b0;
            repeat (3 * B) @(negedge clk);
            RX = 1'b1;
        end
        repeat (B) @(negedge clk);
        if (stop_ok) begin
            chk("ovr", n_ovr, {31'd0, mdl_rdy});
            mdl_rdy  = 1'b1;
            mdl_data = v;
        end else begin
            chk("ovr", n_ovr, 0);
        end
        chk("frm_err", n_frm, {31'd0, !stop_ok});
        chk("go_cmd", n_go, {31'd0, stop_ok && v == GO});
        chk("stop_cmd", n_stop, {31'd0, stop_ok && v == STP});
        chk("rdy", rdy, mdl_rdy);
        chk("rx_data", rx_data, mdl_data);
        if (exp_rise) chk("latency", rise_cyc - start, LAT);
    endtask

    task automatic clr();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        mdl_rdy = 1'b0;
        chk("clr_rdy", rdy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {rx_data, rdy, frm_err, ovr, go_cmd, stop_cmd}, 0);
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;

        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send(GO, 1'b1);
        send(STP, 1'b1);
        clr();
        send(8'hA5, 1'b0);
        send(GO, 1'b1);
        clr();

        // Short low glitch must be rejected with no activity.
        @(negedge clk);
        clear_counts();
        RX = 1'b0;
        repeat (B / 4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("glitch", {n_go, n_stop, n_frm, n_ovr}, 0);
        chk("glitch_rdy", rdy, mdl_rdy);
        send(STP, 1'b1);

        // Overrun: second byte lands while the first is still pending.
        clr();
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);

        // Reset in the middle of the data bits.
        @(negedge clk);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        RX = 1'b1;
        repeat (3 * B) @(negedge clk);
        #3 rst = 1'b1;
        #1 chk_all_zero("mid_rst");
        mdl_rdy  = 1'b0;
        mdl_data = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (B) @(negedge clk);
        send(GO, 1'b1);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       b = GO;
                1:       b = STP;
                default: b = 8'($urandom);
            endcase
            ok = ($urandom_range(0, 6) != 0);
            send(b, ok);
            if ($urandom_range(0, 1) == 1) clr();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
